// File: rtl/core_bridge_pkg.sv
// Shared definitions for the bridge target mailbox: region decode, register
// offsets, handshake magics and the command-issuer state encoding.
package core_bridge_pkg;

  localparam logic [7:0]  REGION_HI      = 8'hF8;
  localparam logic [7:0]  REGION_MID     = 8'h10;

  localparam logic [7:0]  OFF_TARGET0    = 8'h00;
  localparam logic [7:0]  OFF_PARAM_PTR  = 8'h04;
  localparam logic [7:0]  OFF_RESP_PTR   = 8'h08;
  localparam logic [7:0]  OFF_PARAM      = 8'h20;
  localparam logic [7:0]  OFF_RESP       = 8'h40;

  localparam logic [15:0] MAGIC_CMD      = 16'h636D;
  localparam logic [15:0] MAGIC_OK       = 16'h6F6B;
  localparam logic [15:0] RC_TIMEOUT     = 16'hFFFE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } cmdq_state_e;

  // Mailbox lives at 0xF8xx10xx; bits [23:16] are don't-care.
  function automatic logic region_hit(input logic [31:0] addr);
    return (addr[31:24] == REGION_HI) && (addr[15:8] == REGION_MID);
  endfunction

  function automatic logic [31:0] byte_swap(input logic [31:0] d, input logic en);
    return en ? {d[7:0], d[15:8], d[23:16], d[31:24]} : d;
  endfunction

endpackage

// File: rtl/core_bridge_cmdq_fifo.sv
// Synchronous show-ahead FIFO with occupancy count and a registered full flag.
module core_bridge_cmdq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic [LW-1:0]    level_next_s;
  logic             full_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push & ~full_r;
  assign pop_ok_s  = pop & (level_r != LW'(0));

  // Occupancy for the next cycle; simultaneous push and pop cancel out.
  always_comb begin
    level_next_s = level_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_next_s = level_r + LW'(1);
      2'b01:   level_next_s = level_r - LW'(1);
      default: level_next_s = level_r;
    endcase
  end

  // Pointers, level and full flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      full_r   <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      level_r <= level_next_s;
      full_r  <= (level_next_s == LW'(DEPTH));
    end
  end

  // Storage array; contents are qualified by the pointers so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= push_data;
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign full     = full_r;
  assign empty    = (level_r == LW'(0));
  assign level    = level_r;

endmodule

// File: rtl/core_bridge_target_cmdq.sv
// Queued target-to-host command issuer: commands drain from a FIFO through the
// bridge mailbox one at a time, and the host's "ok" reply completes each one.
module core_bridge_target_cmdq
  import core_bridge_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int PARAM_WORDS    = 4,
  parameter int RESP_WORDS     = 4,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      bridge_endian_little,
  input  logic [31:0]               bridge_addr,
  input  logic                      bridge_rd,
  output logic [31:0]               bridge_rd_data,
  input  logic                      bridge_wr,
  input  logic [31:0]               bridge_wr_data,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [15:0]               cmd_code,
  input  logic [32*PARAM_WORDS-1:0] cmd_param,
  input  logic [3:0]                cmd_tag,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [3:0]                rsp_tag,
  output logic [15:0]               rsp_code,
  output logic                      rsp_timeout,
  output logic [32*RESP_WORDS-1:0]  rsp_data,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int PB    = 32 * PARAM_WORDS;
  localparam int EW    = 4 + 16 + PB;
  localparam int TW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  cmdq_state_e   state_r;
  logic [2:0]    endian_sync_r;
  logic [31:0]   target0_r;
  logic [31:0]   param_r [PARAM_WORDS];
  logic [31:0]   resp_r  [RESP_WORDS];
  logic [3:0]    tag_r;
  logic [15:0]   rsp_code_r;
  logic          rsp_timeout_r;
  logic          rsp_valid_r;
  logic          busy_r;
  logic [TW-1:0] wait_cnt_r;
  logic [31:0]   rd_data_r;

  logic          endian_s;
  logic          hit_s;
  logic [7:0]    off_s;
  logic          wr_hit_s;
  logic          rd_hit_s;
  logic [31:0]   wr_data_s;
  logic          t0_wr_s;
  logic          ok_wr_s;
  logic [TW-1:0] wait_cnt_inc_s;
  logic          timeout_s;
  logic [31:0]   param_rd_s;
  logic [31:0]   rd_val_s;
  logic          fifo_push_s;
  logic          fifo_pop_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [EW-1:0] fifo_in_s;
  logic [EW-1:0] fifo_out_s;
  logic          addr_unused_s;

  assign addr_unused_s = ^bridge_addr[23:16];

  // Three-flop synchroniser for the asynchronous endian select.
  always_ff @(posedge clk) begin
    if (!reset_n) endian_sync_r <= 3'b000;
    else          endian_sync_r <= {endian_sync_r[1:0], bridge_endian_little};
  end

  assign endian_s  = endian_sync_r[2];
  assign hit_s     = region_hit(bridge_addr);
  assign off_s     = bridge_addr[7:0];
  assign wr_hit_s  = bridge_wr & hit_s;
  assign rd_hit_s  = bridge_rd & hit_s;
  assign wr_data_s = byte_swap(bridge_wr_data, endian_s);
  assign t0_wr_s   = wr_hit_s && (off_s == OFF_TARGET0);
  assign ok_wr_s   = t0_wr_s && (wr_data_s[31:16] == MAGIC_OK);

  assign fifo_in_s   = {cmd_tag, cmd_code, cmd_param};
  assign fifo_push_s = cmd_valid & cmd_ready;
  assign fifo_pop_s  = (state_r == ST_IDLE) & ~fifo_empty_s;

  core_bridge_cmdq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push_s),
    .push_data (fifo_in_s),
    .pop       (fifo_pop_s),
    .pop_data  (fifo_out_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (level)
  );

  assign cmd_ready = ~fifo_full_s;

  // Saturating wait counter increment and timeout detection.
  always_comb begin
    wait_cnt_inc_s = (wait_cnt_r == {TW{1'b1}}) ? wait_cnt_r : wait_cnt_r + TW'(1);
    if (TO_EN && (wait_cnt_inc_s == TW'(TIMEOUT_CYCLES))) timeout_s = 1'b1;
    else                                                  timeout_s = 1'b0;
  end

  // Command FSM together with the mailbox registers it owns.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      target0_r     <= 32'h0;
      tag_r         <= 4'h0;
      rsp_code_r    <= 16'h0;
      rsp_timeout_r <= 1'b0;
      rsp_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
      wait_cnt_r    <= '0;
      for (int k = 0; k < PARAM_WORDS; k++) param_r[k] <= 32'h0;
      for (int k = 0; k < RESP_WORDS; k++)  resp_r[k]  <= 32'h0;
    end else begin
      if (t0_wr_s) target0_r <= wr_data_s;
      for (int k = 0; k < RESP_WORDS; k++) begin
        if (wr_hit_s && (off_s == OFF_RESP + 8'(4 * k))) resp_r[k] <= wr_data_s;
      end
      case (state_r)
        ST_IDLE: begin
          // Issue overrides any same-edge host write to target_0.
          if (fifo_pop_s) begin
            for (int k = 0; k < PARAM_WORDS; k++) param_r[k] <= fifo_out_s[32*k +: 32];
            for (int k = 0; k < RESP_WORDS; k++)  resp_r[k]  <= 32'h0;
            target0_r  <= {MAGIC_CMD, fifo_out_s[PB +: 16]};
            tag_r      <= fifo_out_s[PB+16 +: 4];
            wait_cnt_r <= '0;
            busy_r     <= 1'b1;
            state_r    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ok_wr_s) begin
            rsp_code_r  <= wr_data_s[15:0];
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end else if (timeout_s) begin
            rsp_code_r    <= RC_TIMEOUT;
            rsp_timeout_r <= 1'b1;
            rsp_valid_r   <= 1'b1;
            target0_r     <= 32'h0;
            state_r       <= ST_RESP;
          end else begin
            wait_cnt_r <= wait_cnt_inc_s;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r   <= 1'b0;
            rsp_timeout_r <= 1'b0;
            busy_r        <= 1'b0;
            state_r       <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  // Parameter-word readback; yields zero when no parameter slot matches.
  always_comb begin
    param_rd_s = 32'h0;
    for (int k = 0; k < PARAM_WORDS; k++) begin
      param_rd_s = param_rd_s | ({32{off_s == OFF_PARAM + 8'(4 * k)}} & param_r[k]);
    end
  end

  // Read decode; response words and unmapped offsets return zero.
  always_comb begin
    rd_val_s = 32'h0;
    case (off_s)
      OFF_TARGET0:   rd_val_s = target0_r;
      OFF_PARAM_PTR: rd_val_s = {24'h0, OFF_PARAM};
      OFF_RESP_PTR:  rd_val_s = {24'h0, OFF_RESP};
      default:       rd_val_s = param_rd_s;
    endcase
  end

  // Registered read data; holds its value outside the mailbox region.
  always_ff @(posedge clk) begin
    if (!reset_n)      rd_data_r <= 32'h0;
    else if (rd_hit_s) rd_data_r <= byte_swap(rd_val_s, endian_s);
    else               rd_data_r <= rd_data_r;
  end

  always_comb begin
    rsp_data = '0;
    for (int k = 0; k < RESP_WORDS; k++) rsp_data[32*k +: 32] = resp_r[k];
  end

  assign bridge_rd_data = rd_data_r;
  assign rsp_valid      = rsp_valid_r;
  assign rsp_tag        = tag_r;
  assign rsp_code       = rsp_code_r;
  assign rsp_timeout    = rsp_timeout_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_core_bridge_target_cmdq.sv
// Directed scoreboard bench for core_bridge_target_cmdq (DEPTH=4, 16-cycle timeout).
module tb_core_bridge_target_cmdq;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         bridge_endian_little;
  logic [31:0]  bridge_addr;
  logic         bridge_rd;
  logic [31:0]  bridge_rd_data;
  logic         bridge_wr;
  logic [31:0]  bridge_wr_data;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [15:0]  cmd_code;
  logic [127:0] cmd_param;
  logic [3:0]   cmd_tag;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [3:0]   rsp_tag;
  logic [15:0]  rsp_code;
  logic         rsp_timeout;
  logic [127:0] rsp_data;
  logic         busy;
  logic [2:0]   level;

  typedef struct {
    logic [3:0]  tag;
    logic [15:0] code;
    logic [31:0] data0;
    logic        to;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  core_bridge_target_cmdq #(
    .DEPTH(4), .PARAM_WORDS(4), .RESP_WORDS(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bridge_endian_little(bridge_endian_little),
    .bridge_addr(bridge_addr), .bridge_rd(bridge_rd), .bridge_rd_data(bridge_rd_data),
    .bridge_wr(bridge_wr), .bridge_wr_data(bridge_wr_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_param(cmd_param), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
    .rsp_code(rsp_code), .rsp_timeout(rsp_timeout), .rsp_data(rsp_data),
    .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] mb(input logic [7:0] off);
    return {8'hF8, 8'h5A, 8'h10, off};
  endfunction

  task automatic bwrite(input logic [31:0] addr, input logic [31:0] data);
    bridge_addr    = addr;
    bridge_wr_data = data;
    bridge_wr      = 1'b1;
    tick();
    bridge_wr      = 1'b0;
  endtask

  task automatic bread(input logic [31:0] addr, output logic [31:0] data);
    bridge_addr = addr;
    bridge_rd   = 1'b1;
    tick();
    bridge_rd   = 1'b0;
    data        = bridge_rd_data;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] d;
    bread(mb(off), d);
    chk(name, d, exp);
  endtask

  // Push one command; the planned reply is recorded in the scoreboard.
  task automatic push_cmd(input logic [15:0] code, input logic [127:0] prm, input logic [3:0] tag,
                          input logic [15:0] e_code, input logic [31:0] e_data0, input logic e_to);
    int n = 0;
    exp_t e;
    cmd_code  = code;
    cmd_param = prm;
    cmd_tag   = tag;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (cmd_ready !== 1'b1) chk("push_wait", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    e.tag = tag; e.code = e_code; e.data0 = e_data0; e.to = e_to;
    sb_q.push_back(e);
  endtask

  task automatic wait_rsp(input int max);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk("rsp_wait", rsp_valid, 1'b1);
  endtask

  task automatic check_rsp();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 1'b1, 1'b0);
    end else begin
      e = sb_q.pop_front();
      chk("rsp_tag", rsp_tag, e.tag);
      chk("rsp_code", rsp_code, e.code);
      chk("rsp_data0", rsp_data[31:0], e.data0);
      chk("rsp_timeout", rsp_timeout, e.to);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_after_ack", rsp_valid, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; bridge_endian_little = 1'b0; bridge_addr = 32'h0;
    bridge_rd = 1'b0; bridge_wr = 1'b0; bridge_wr_data = 32'h0;
    cmd_valid = 1'b0; cmd_code = 16'h0; cmd_param = 128'h0; cmd_tag = 4'h0;
    rsp_ready = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;

    // Reset state
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_level", level, 3'd0);
    chk("rst_rd_data", bridge_rd_data, 32'h0);
    chk("rst_rsp_code", rsp_code, 16'h0);

    // Basic command: code 0x0140, params 1..4, tag 5
    push_cmd(16'h0140, {32'd4, 32'd3, 32'd2, 32'd1}, 4'd5, 16'h0000, 32'hAA, 1'b0);
    tick();
    chk("busy_wait", busy, 1'b1);
    rd_chk("t1_target0", 8'h00, 32'h636D0140);
    rd_chk("t1_param0", 8'h20, 32'd1);
    rd_chk("t1_param1", 8'h24, 32'd2);
    rd_chk("t1_param2", 8'h28, 32'd3);
    rd_chk("t1_param3", 8'h2C, 32'd4);
    rd_chk("t1_off04", 8'h04, 32'h20);
    rd_chk("t1_off08", 8'h08, 32'h40);
    begin
      logic [31:0] d;
      bread(32'hF85A2000, d);
      chk("t1_out_of_region_hold", d, 32'h40);
    end
    rd_chk("t1_resp_read_zero", 8'h40, 32'h0);
    bwrite(mb(8'h40), 32'hAA);
    chk("t1_pre_ok_valid", rsp_valid, 1'b0);
    bwrite(mb(8'h00), 32'h6F6B0000);
    chk("t1_ok_latency", rsp_valid, 1'b1);
    check_rsp();

    // FIFO fill with stalled host: 1 issued + DEPTH queued
    for (int i = 1; i <= 5; i++)
      push_cmd(16'h0200 + 16'(i), 128'(i), 4'(i), 16'h1000 + 16'(i), 32'h0, 1'b0);
    chk("t2_full_ready", cmd_ready, 1'b0);
    chk("t2_full_level", level, 3'd4);
    cmd_valid = 1'b1; cmd_tag = 4'hF;
    tick();
    cmd_valid = 1'b0;
    chk("t2_overflow_level", level, 3'd4);
    for (int i = 1; i <= 5; i++) begin
      bwrite(mb(8'h00), {16'h6F6B, 16'h1000 + 16'(i)});
      wait_rsp(4);
      check_rsp();
      tick();
      if (i == 1) begin
        chk("t2_ready_after_pop", cmd_ready, 1'b1);
        chk("t2_level_after_pop", level, 3'd3);
      end
    end
    chk("t2_drained_level", level, 3'd0);

    // Timeout after 16 WAIT cycles, late ok dropped
    push_cmd(16'h0300, 128'h0, 4'd9, 16'hFFFE, 32'h0, 1'b1);
    tick();
    repeat (15) tick();
    chk("t3_no_early_timeout", rsp_valid, 1'b0);
    tick();
    chk("t3_timeout_valid", rsp_valid, 1'b1);
    rd_chk("t3_target0_cleared", 8'h00, 32'h0);
    check_rsp();
    tick();
    bwrite(mb(8'h00), 32'h6F6B0003);
    repeat (3) tick();
    chk("t3_late_ok_no_rsp", rsp_valid, 1'b0);
    chk("t3_late_ok_idle", busy, 1'b0);
    rd_chk("t3_late_ok_target0", 8'h00, 32'h6F6B0003);

    // Little-endian bus
    bridge_endian_little = 1'b1;
    repeat (4) tick();
    push_cmd(16'h0042, 128'h0, 4'd3, 16'h0000, 32'h12345678, 1'b0);
    tick();
    rd_chk("t4_off04_le", 8'h04, 32'h20000000);
    bwrite(mb(8'h40), 32'h78563412);
    bwrite(mb(8'h00), 32'h00006B6F);
    wait_rsp(2);
    rd_chk("t4_target0_le", 8'h00, 32'h00006B6F);
    check_rsp();
    bridge_endian_little = 1'b0;
    repeat (4) tick();

    // Reset mid-WAIT with two commands queued
    rd_chk("t5_pre_read", 8'h04, 32'h20);
    for (int i = 0; i < 3; i++)
      push_cmd(16'h0500 + 16'(i), 128'h77, 4'(10 + i), 16'h0, 32'h0, 1'b0);
    chk("t5_level_queued", level, 3'd2);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    sb_q.delete();
    chk("t5_level", level, 3'd0);
    chk("t5_cmd_ready", cmd_ready, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_rsp_valid", rsp_valid, 1'b0);
    chk("t5_rsp_code", rsp_code, 16'h0);
    chk("t5_rsp_tag", rsp_tag, 4'h0);
    chk("t5_rsp_timeout", rsp_timeout, 1'b0);
    chk("t5_rsp_data", rsp_data[63:0], 64'h0);
    chk("t5_rd_data", bridge_rd_data, 32'h0);
    repeat (2) tick();
    chk("t5_no_issue", busy, 1'b0);
    rd_chk("t5_target0", 8'h00, 32'h0);
    rd_chk("t5_param0", 8'h20, 32'h0);
    push_cmd(16'h0777, 128'h0, 4'd7, 16'h0055, 32'h0, 1'b0);
    tick();
    rd_chk("t5_new_target0", 8'h00, 32'h636D0777);
    bwrite(mb(8'h00), 32'h6F6B0055);
    wait_rsp(2);
    check_rsp();

    // rsp_ready held low: outputs stable, no second issue
    push_cmd(16'h0A0A, 128'h0, 4'hA, 16'h0011, 32'h5A5A, 1'b0);
    push_cmd(16'h0B0B, 128'h0, 4'hB, 16'h0022, 32'h0, 1'b0);
    bwrite(mb(8'h40), 32'h5A5A);
    bwrite(mb(8'h00), 32'h6F6B0011);
    wait_rsp(2);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_hold_valid", rsp_valid, 1'b1);
      chk("t6_hold_tag", rsp_tag, 4'hA);
      chk("t6_hold_code", rsp_code, 16'h0011);
      chk("t6_hold_level", level, 3'd1);
    end
    check_rsp();
    tick();
    bwrite(mb(8'h00), 32'h6F6B0022);
    wait_rsp(2);
    check_rsp();
    chk("t6_sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
